commit_trace_fifo: RTL and testbench

- Sits directly downstream of core_model and consumes its per-retirement commit signals: pc, update, instr, rd address/data, memory address/data and enables.
- Classifies each retired instruction (reg write / load / store / none), buffers the records in a FIFO and drains them over a valid/ready interface to a trace sink (UART packer, host DMA).
- Detects the end-of-test self-loop instruction and raises done only after the FIFO has fully drained.

---
 rtl/commit_trace_fifo.sv | 174 +++++++++++++++++
 tb/tb_commit_trace_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: classifies retired instructions, buffers them and drains them over valid/ready.
// Optional macro COMMIT_TRACE_SEQ_EN adds a 32-bit per-capture sequence number (rec_seq_o).
module commit_trace_fifo #(
  parameter int          XLEN       = 32,
  parameter int          DEPTH      = 8,
  parameter int          DROP_CNT_W = 16,
  parameter logic [31:0] HALT_INSTR = 32'h0000006f
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic                     reg_we_i,
  input  logic                     mem_re_i,
  input  logic                     mem_we_i,
  input  logic [XLEN-1:0]          mem_raddr_i,
  input  logic [XLEN-1:0]          mem_waddr_i,
  input  logic [XLEN-1:0]          mem_wdata_i,
  input  logic [1:0]               store_size_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [1:0]               rec_kind_o,
  output logic [XLEN-1:0]          rec_pc_o,
  output logic [31:0]              rec_instr_o,
  output logic [4:0]               rec_rd_o,
  output logic [XLEN-1:0]          rec_data_o,
  output logic [XLEN-1:0]          rec_addr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o,
  output logic                     done_o
`ifdef COMMIT_TRACE_SEQ_EN
  ,
  output logic [31:0]              rec_seq_o
`endif
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {KIND_NONE = 2'd0, KIND_REG = 2'd1, KIND_LOAD = 2'd2, KIND_STORE = 2'd3} kind_e;
  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_DONE} state_e;

  typedef struct packed {
    kind_e           kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
`ifdef COMMIT_TRACE_SEQ_EN
    logic [31:0]     seq;
`endif
  } rec_t;

  rec_t                  mem_q [DEPTH];
  rec_t                  rec_d, head;
  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  capture, valid, pop, push, drop;
`ifdef COMMIT_TRACE_SEQ_EN
  logic [31:0]           seq_q, seq_d;
`endif

  // Record classification: store wins over load, load over plain register write.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rec_d       = '0;
    rec_d.pc    = pc_i;
    rec_d.instr = instr_i;
`ifdef COMMIT_TRACE_SEQ_EN
    rec_d.seq   = seq_q;
`endif
    if (mem_we_i) begin
      rec_d.kind = KIND_STORE;
      rec_d.addr = mem_waddr_i;
      case (store_size_i)
        2'd0:    rec_d.data = {{(XLEN-8){1'b0}}, mem_wdata_i[7:0]};
        2'd1:    rec_d.data = {{(XLEN-16){1'b0}}, mem_wdata_i[15:0]};
        default: rec_d.data = mem_wdata_i;
      endcase
    end else if (mem_re_i && reg_addr_i != 5'd0) begin
      rec_d.kind = KIND_LOAD;
      rec_d.rd   = reg_addr_i;
      rec_d.data = reg_data_i;
      rec_d.addr = mem_raddr_i;
    end else if (reg_we_i && reg_addr_i != 5'd0) begin
      rec_d.kind = KIND_REG;
      rec_d.rd   = reg_addr_i;
      rec_d.data = reg_data_i;
    end
  end

  always_comb begin
    capture    = update_i && (pc_i != '0) && (state_q == ST_RUN);
    valid      = (count_q != '0);
    pop        = valid && rec_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = capture && ((count_q != FULL_CNT) || pop);
    drop       = capture && !push;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;
`ifdef COMMIT_TRACE_SEQ_EN
    seq_d      = capture ? seq_q + 32'd1 : seq_q;
`endif
    state_d    = state_q;
    case (state_q)
      ST_RUN:    if (capture && instr_i == HALT_INSTR) state_d = ST_HALTED;
      ST_HALTED: if (count_q == '0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef COMMIT_TRACE_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef COMMIT_TRACE_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

  // NOTE: the storage array is not reset; count and pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_d;
  end

  // Record fields are forced to zero while empty so reset leaves every output at 0.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    rec_valid_o = valid;
    rec_kind_o  = valid ? head.kind  : KIND_NONE;
    rec_pc_o    = valid ? head.pc    : '0;
    rec_instr_o = valid ? head.instr : '0;
    rec_rd_o    = valid ? head.rd    : '0;
    rec_data_o  = valid ? head.data  : '0;
    rec_addr_o  = valid ? head.addr  : '0;
`ifdef COMMIT_TRACE_SEQ_EN
    rec_seq_o   = valid ? head.seq   : '0;
`endif
    count_o     = count_q;
    overflow_o  = overflow_q;
    drop_cnt_o  = drop_cnt_q;
    done_o      = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo: directed scenarios plus randomized traffic against a queue model.
// Honours COMMIT_TRACE_SEQ_EN when the design is built with it.
module tb_commit_trace_fifo;

  localparam int          DEPTH = 8;
  localparam logic [31:0] HALT  = 32'h0000006f;

  logic        clk = 1'b0;
  logic        rstn;
  logic        update_i;
  logic [31:0] pc_i, instr_i, reg_data_i, mem_raddr_i, mem_waddr_i, mem_wdata_i;
  logic [4:0]  reg_addr_i;
  logic        reg_we_i, mem_re_i, mem_we_i, rec_ready_i;
  logic [1:0]  store_size_i;
  logic        rec_valid_o, overflow_o, done_o;
  logic [1:0]  rec_kind_o;
  logic [31:0] rec_pc_o, rec_instr_o, rec_data_o, rec_addr_o;
  logic [4:0]  rec_rd_o;
  logic [3:0]  count_o;
  logic [15:0] drop_cnt_o;
`ifdef COMMIT_TRACE_SEQ_EN
  logic [31:0] rec_seq_o;
`endif

  commit_trace_fifo dut (
    .clk(clk), .rstn(rstn), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
    .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .reg_we_i(reg_we_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_raddr_i(mem_raddr_i),
    .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i), .store_size_i(store_size_i),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_kind_o(rec_kind_o),
    .rec_pc_o(rec_pc_o), .rec_instr_o(rec_instr_o), .rec_rd_o(rec_rd_o),
    .rec_data_o(rec_data_o), .rec_addr_o(rec_addr_o), .count_o(count_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .done_o(done_o)
`ifdef COMMIT_TRACE_SEQ_EN
    , .rec_seq_o(rec_seq_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc, instr, data, addr, seq;
    logic [4:0]  rd;
  } mrec_t;

  mrec_t       q[$];
  bit          m_halted, m_done, m_ovf;
  logic [15:0] m_drops;
  logic [31:0] m_seq;
  int          tests  = 0;
  int          failed = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic mrec_t classify();
    mrec_t r;
    r = '{default: '0};
    r.pc    = pc_i;
    r.instr = instr_i;
    if (mem_we_i) begin
      r.kind = 2'd3;
      r.addr = mem_waddr_i;
      if (store_size_i == 2'd0)      r.data = mem_wdata_i & 32'h0000_00ff;
      else if (store_size_i == 2'd1) r.data = mem_wdata_i & 32'h0000_ffff;
      else                           r.data = mem_wdata_i;
    end else if (mem_re_i && reg_addr_i != 0) begin
      r.kind = 2'd2; r.rd = reg_addr_i; r.data = reg_data_i; r.addr = mem_raddr_i;
    end else if (reg_we_i && reg_addr_i != 0) begin
      r.kind = 2'd1; r.rd = reg_addr_i; r.data = reg_data_i;
    end
    return r;
  endfunction

  task automatic check_state();
    check("valid", 32'(rec_valid_o), 32'(q.size() != 0));
    check("count", 32'(count_o), 32'(q.size()));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt_o), 32'(m_drops));
    check("done", 32'(done_o), 32'(m_done));
    if (q.size() != 0) begin
      check("head_kind", 32'(rec_kind_o), 32'(q[0].kind));
      check("head_pc", rec_pc_o, q[0].pc);
      check("head_instr", rec_instr_o, q[0].instr);
      check("head_rd", 32'(rec_rd_o), 32'(q[0].rd));
      check("head_data", rec_data_o, q[0].data);
      check("head_addr", rec_addr_o, q[0].addr);
`ifdef COMMIT_TRACE_SEQ_EN
      check("head_seq", rec_seq_o, q[0].seq);
`endif
    end
  endtask

  // Advance one clock: update the model from the inputs in force, then compare after the edge.
  task automatic cycle();
    bit cap, pop, become_done;
    cap         = update_i && pc_i != 0 && !m_halted;
    pop         = (q.size() != 0) && rec_ready_i;
    become_done = m_halted && !m_done && q.size() == 0;
    if (pop) void'(q.pop_front());
    if (cap) begin
      mrec_t r;
      r     = classify();
      r.seq = m_seq;
      m_seq = m_seq + 1;
      if (q.size() < DEPTH) q.push_back(r);
      else begin
        m_ovf = 1'b1;
        if (m_drops != 16'hffff) m_drops = m_drops + 1;
      end
      if (instr_i == HALT) m_halted = 1'b1;
    end
    if (become_done) m_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic idle();
    update_i = 0; reg_we_i = 0; mem_re_i = 0; mem_we_i = 0;
    pc_i = 0; instr_i = 0; reg_addr_i = 0; reg_data_i = 0;
    mem_raddr_i = 0; mem_waddr_i = 0; mem_wdata_i = 0; store_size_i = 0;
  endtask

  task automatic retire_reg(logic [31:0] pc, logic [31:0] instr, logic [4:0] rd, logic [31:0] data);
    idle();
    update_i = 1; pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = data; reg_we_i = 1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1;
    q.delete();
    m_halted = 0; m_done = 0; m_ovf = 0; m_drops = 0; m_seq = 0;
    check_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    rec_ready_i = 0;
    idle();
    @(negedge clk);
    do_reset();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(rec_valid_o), 32'd0);

    // Single ALU retire, drained immediately.
    rec_ready_i = 1;
    retire_reg(32'h8000_0004, 32'h0050_0093, 5'd1, 32'd5);
    cycle();
    check("alu_valid", 32'(rec_valid_o), 32'd1);
    check("alu_kind", 32'(rec_kind_o), 32'd1);
    check("alu_rd", 32'(rec_rd_o), 32'd1);
    check("alu_data", rec_data_o, 32'h5);
    check("alu_addr", rec_addr_o, 32'h0);
    idle();
    cycle();
    check("alu_drained", 32'(rec_valid_o), 32'd0);

    // Store byte then store half.
    idle();
    update_i = 1; pc_i = 32'h8000_0008; instr_i = 32'h00a1_0023; reg_addr_i = 5'd5;
    mem_we_i = 1; mem_waddr_i = 32'h8000_1000; mem_wdata_i = 32'hDEAD_BEEF; store_size_i = 2'd0;
    cycle();
    check("sb_kind", 32'(rec_kind_o), 32'd3);
    check("sb_data", rec_data_o, 32'h0000_00EF);
    check("sb_rd", 32'(rec_rd_o), 32'd0);
    check("sb_addr", rec_addr_o, 32'h8000_1000);
    pc_i = 32'h8000_000c; instr_i = 32'h00a1_1023; store_size_i = 2'd1;
    cycle();
    check("sh_data", rec_data_o, 32'h0000_BEEF);
    idle();
    cycle();

    // Load to x0 is kind none; load to x10 is kind load.
    update_i = 1; pc_i = 32'h8000_0010; instr_i = 32'h0000_2003; mem_re_i = 1;
    reg_addr_i = 5'd0; mem_raddr_i = 32'h8000_2000; reg_data_i = 32'h1234;
    cycle();
    check("ld_x0_kind", 32'(rec_kind_o), 32'd0);
    pc_i = 32'h8000_0014; instr_i = 32'h0000_2503; reg_addr_i = 5'd10;
    cycle();
    check("ld_x10_kind", 32'(rec_kind_o), 32'd2);
    check("ld_x10_addr", rec_addr_o, 32'h8000_2000);
    idle();
    cycle();

    // Overflow: ten retires into eight entries with the sink stalled.
    rec_ready_i = 0;
    for (int i = 0; i < 10; i++) begin
      retire_reg(32'h8001_0000 + 32'(4 * i), 32'h0010_0093, 5'(1 + i), 32'(100 + i));
      cycle();
    end
    idle();
    cycle();
    check("ovf_count", 32'(count_o), 32'd8);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_drops", 32'(drop_cnt_o), 32'd2);
    check("ovf_head_pc", rec_pc_o, 32'h8001_0000);

    // Full with a simultaneous pop: push accepted, occupancy unchanged.
    rec_ready_i = 1;
    retire_reg(32'h8002_0000, 32'h0020_0093, 5'd2, 32'd77);
    cycle();
    check("fullpop_count", 32'(count_o), 32'd8);
    check("fullpop_drops", 32'(drop_cnt_o), 32'd2);
    check("fullpop_head_pc", rec_pc_o, 32'h8001_0004);
    idle();
    for (int i = 0; i < DEPTH; i++) cycle();
    check("ovf_drained", 32'(rec_valid_o), 32'd0);

    // Randomized traffic (no halt instruction).
    for (int i = 0; i < 400; i++) begin
      update_i     = ($urandom_range(0, 9) < 6);
      pc_i         = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      instr_i      = $urandom;
      if (instr_i == HALT) instr_i = instr_i ^ 32'h100;
      reg_addr_i   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      reg_data_i   = $urandom;
      reg_we_i     = 1'($urandom);
      mem_re_i     = 1'($urandom);
      mem_we_i     = ($urandom_range(0, 3) == 0);
      mem_raddr_i  = $urandom;
      mem_waddr_i  = $urandom;
      mem_wdata_i  = $urandom;
      store_size_i = 2'($urandom);
      rec_ready_i  = 1'($urandom);
      cycle();
    end
    idle();
    rec_ready_i = 1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();

    // Halt: three records, the halt record, two ignored retires.
    do_reset();
    rec_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      retire_reg(32'h8003_0000 + 32'(4 * i), 32'h0030_0093, 5'(3 + i), 32'(i));
      cycle();
    end
    idle();
    update_i = 1; pc_i = 32'h8003_0010; instr_i = HALT;
    cycle();
    for (int i = 0; i < 2; i++) begin
      retire_reg(32'h8003_0020 + 32'(4 * i), 32'h0040_0093, 5'd4, 32'd9);
      cycle();
    end
    idle();
    check("halt_count", 32'(count_o), 32'd4);
    check("halt_done_early", 32'(done_o), 32'd0);
    rec_ready_i = 1;
    for (int i = 0; i < 4; i++) cycle();
    check("halt_empty", 32'(count_o), 32'd0);
    check("halt_done_not_yet", 32'(done_o), 32'd0);
    cycle();
    check("halt_done", 32'(done_o), 32'd1);
    retire_reg(32'h8003_0040, 32'h0050_0093, 5'd5, 32'd1);
    cycle();
    cycle();
    check("done_held", 32'(done_o), 32'd1);
    check("done_ignores", 32'(count_o), 32'd0);

    do_reset();
    check("post_rst_done", 32'(done_o), 32'd0);
    check("post_rst_count", 32'(count_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
